program_loader: RTL and testbench

Boot-time sequencer for the program memory write port. It accepts a byte stream over a valid/ready handshake and checks a length header. It assembles little-endian 32-bit words, writes them to consecutive word addresses, and verifies a trailing XOR checksum. It holds the CPU off the fetch path for the whole load and reports completion or error to the top level.

---
 rtl/program_loader.sv | 143 ++++++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream, packs little-endian
// words into program memory at consecutive addresses and checks a trailing XOR checksum.
module program_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_write_enable,
    output logic [31:0] mem_byte_address,
    output logic [31:0] mem_write_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [2:0]  debug_state
);

    // Handshake: a byte moves on a rising edge where in_valid && in_ready; the source
    // must hold in_data stable while in_valid is high and in_ready is low.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CSUM   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state, state_next;
    logic [15:0] count;
    logic [15:0] word_index;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic        xfer;
    logic [15:0] hdr_count;
    logic        hdr_ok;

    assign xfer      = in_valid && in_ready;
    assign hdr_count = {in_data, count[7:0]};
    assign hdr_ok    = (hdr_count != 16'd0) && ({1'b0, hdr_count} <= DEPTH_W);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = hdr_ok ? S_DATA : S_IDLE;
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = (word_index + 16'd1 == count) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign mem_write_enable = (state == S_WRITE);
    assign cpu_hold         = (state != S_IDLE);
    assign mem_byte_address = BASE_ADDR + {14'd0, word_index, 2'b00};
    assign debug_state      = state;

    // load_done is registered so a header error can pulse it while already back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            count          <= 16'd0;
            word_index     <= 16'd0;
            byte_cnt       <= 2'd0;
            csum           <= 8'd0;
            mem_write_data <= 32'd0;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
        end else begin
            state     <= state_next;
            load_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        load_error <= 1'b0;
                        word_index <= 16'd0;
                        byte_cnt   <= 2'd0;
                        csum       <= 8'd0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) count[7:0] <= in_data;
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        count[15:8] <= in_data;
                        if (!hdr_ok) begin
                            load_error <= 1'b1;
                            load_done  <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        mem_write_data[{byte_cnt, 3'b000} +: 8] <= in_data;
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    word_index <= word_index + 16'd1;
                end
                S_CSUM: begin
                    if (xfer) begin
                        load_done <= 1'b1;
                        if (in_data != csum) load_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a stream-level model derives expected writes,
// completion and error status for each load and a scoreboard checks every write strobe.
module tb_program_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_write_enable;
    logic [31:0] mem_byte_address;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [2:0]  debug_state;

    int          vectors;
    int          miscompares;
    int          done_cnt;
    int          cyc_cnt;
    logic [63:0] exp_q[$];
    logic [7:0]  stim_q[$];

    program_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .mem_write_enable (mem_write_enable),
        .mem_byte_address (mem_byte_address),
        .mem_write_data   (mem_write_data),
        .cpu_hold         (cpu_hold),
        .load_done        (load_done),
        .load_error       (load_error),
        .debug_state      (debug_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every write strobe must match the next expected {address, data}
    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) begin
            check("write_in_ready", 64'(in_ready), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_byte_address, mem_write_data}, 64'hx);
            end else begin
                check("write", {mem_byte_address, mem_write_data}, exp_q.pop_front());
            end
        end
        if (load_done === 1'b1) done_cnt++;
    end

    // reference model: interprets the stream in stim_q
    task automatic model_load(output bit hdr_err, output bit exp_err, output int cnt);
        int          x;
        logic [31:0] word;
        cnt     = int'(stim_q[0]) + 256 * int'(stim_q[1]);
        hdr_err = (cnt < 1) || (cnt > DEPTH);
        exp_err = hdr_err;
        if (!hdr_err) begin
            x = 0;
            for (int w = 0; w < cnt; w++) begin
                word = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    word = word | (32'(stim_q[2 + 4*w + k]) << (8*k));
                    x    = x ^ int'(stim_q[2 + 4*w + k]);
                end
                exp_q.push_back({BASE + 32'(4*w), word});
            end
            exp_err = (int'(stim_q[2 + 4*cnt]) != x);
        end
    endtask

    task automatic gen_load(input int cnt, input bit bad);
        logic [15:0] c16;
        logic [7:0]  x;
        logic [7:0]  b;
        c16 = 16'(cnt);
        stim_q.delete();
        stim_q.push_back(c16[7:0]);
        stim_q.push_back(c16[15:8]);
        if (cnt >= 1 && cnt <= DEPTH) begin
            x = 8'd0;
            for (int i = 0; i < 4*cnt; i++) begin
                b = 8'($urandom);
                stim_q.push_back(b);
                x = x ^ b;
            end
            if (bad) x = x ^ 8'($urandom_range(1, 255));
            stim_q.push_back(x);
        end
    endtask

    // driver tasks; all start and end on a falling edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int cyc;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        cyc      = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_wait", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_we"},       64'(mem_write_enable), 64'd0);
        check({tag, "_addr"},     64'(mem_byte_address), 64'(BASE));
        check({tag, "_data"},     64'(mem_write_data), 64'd0);
        check({tag, "_hold"},     64'(cpu_hold), 64'd0);
        check({tag, "_done"},     64'(load_done), 64'd0);
        check({tag, "_error"},    64'(load_error), 64'd0);
    endtask

    task automatic run_load(input int max_gap, input bit mid_start);
        bit hdr_err;
        bit exp_err;
        int cnt;
        int prev;
        int c0;
        model_load(hdr_err, exp_err, cnt);
        prev = done_cnt;
        c0   = cyc_cnt;
        pulse_start();
        check("hold_after_start",  64'(cpu_hold), 64'd1);
        check("ready_after_start", 64'(in_ready), 64'd1);
        check("error_cleared",     64'(load_error), 64'd0);
        for (int i = 0; i < stim_q.size(); i++) begin
            send_byte(stim_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            if (mid_start && i == 3) pulse_start();
        end
        check("done_pulse", 64'(load_done), 64'd1);
        check("done_error", 64'(load_error), 64'(exp_err));
        check("done_hold",  64'(cpu_hold), hdr_err ? 64'd0 : 64'd1);
        if (max_gap == 0 && !mid_start)
            check("gapless_cycles", 64'(cyc_cnt - c0), hdr_err ? 64'd3 : 64'(5*cnt + 4));
        @(negedge clk);
        @(negedge clk);
        check("done_once",     64'(done_cnt - prev), 64'd1);
        check("hold_released", 64'(cpu_hold), 64'd0);
        check("error_sticky",  64'(load_error), 64'(exp_err));
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] two_word[11];
        logic [7:0] bad_one[7];
        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        reset       = 1'b1;
        start       = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'hA5;

        repeat (3) begin
            @(negedge clk);
            check_reset_values("reset");
        end
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_values("post_reset");

        two_word = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12, 8'h34};
        stim_q.delete();
        foreach (two_word[i]) stim_q.push_back(two_word[i]);
        run_load(0, 1'b0);

        stim_q = '{8'h00, 8'h00};
        run_load(0, 1'b0);
        stim_q = '{8'h01, 8'h01};
        run_load(0, 1'b0);
        gen_load(1, 1'b0);
        run_load(0, 1'b0);

        bad_one = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        stim_q.delete();
        foreach (bad_one[i]) stim_q.push_back(bad_one[i]);
        run_load(0, 1'b0);

        gen_load(3, 1'b0);
        run_load(3, 1'b1);

        // reset right after the 6th byte, while word 0 is being written
        gen_load(3, 1'b0);
        exp_q.push_back({BASE, stim_q[5], stim_q[4], stim_q[3], stim_q[2]});
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stim_q[i], 0);
        check("mid_reset_we", 64'(mem_write_enable), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("mid_reset");
        check("mid_reset_writes", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        gen_load(2, 1'b0);
        run_load(0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            int cnt;
            if ($urandom_range(0, 7) == 0)
                cnt = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(DEPTH + 1, 65535));
            else
                cnt = int'($urandom_range(1, 6));
            gen_load(cnt, $urandom_range(0, 3) == 0);
            run_load(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
